// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// latency-counter sizing and load-data extension.
package lsu_pkg;

  localparam int LSU_ADDR_W  = 18;
  localparam int LSU_DATA_W  = 32;
  localparam int LSU_MEM_LAT = 1;

  typedef enum logic [2:0] {
    LSU_IDLE   = 3'd0,
    LSU_SETUP  = 3'd1,
    LSU_STROBE = 3'd2,
    LSU_WAIT   = 3'd3,
    LSU_RESP   = 3'd4
  } lsu_state_e;

  // Plain vector constants so the state register stays a simple logic vector.
  localparam logic [2:0] ST_IDLE   = LSU_IDLE;
  localparam logic [2:0] ST_SETUP  = LSU_SETUP;
  localparam logic [2:0] ST_STROBE = LSU_STROBE;
  localparam logic [2:0] ST_WAIT   = LSU_WAIT;
  localparam logic [2:0] ST_RESP   = LSU_RESP;

  // The WAIT counter runs from lat-1 down to 0.
  function automatic int lat_cnt_w(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

  function automatic logic [LSU_DATA_W-1:0] extend_load(
    input logic [LSU_DATA_W-1:0] data,
    input logic                  is_byte,
    input logic                  is_signed
  );
    if (is_byte) begin
      return {{(LSU_DATA_W-8){is_signed & data[7]}}, data[7:0]};
    end
    return data;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundles for the load/store unit: datapath request/response channel and
// the data-memory control bus.
interface lsu_req_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_byte;
  logic              req_signed;
  logic [DATA_W-1:0] req_base;
  logic [15:0]       req_offset;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_byte, req_signed, req_base, req_offset,
           req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_signed, req_base, req_offset,
           req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic              mem_byte;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output mem_address, mem_write_data, mem_read, mem_write, mem_byte,
    input  mem_read_data
  );

  modport slave (
    input  mem_address, mem_write_data, mem_read, mem_write, mem_byte,
    output mem_read_data
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Load-result formatter: passes a word through or zero/sign-extends the low byte.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [LSU_DATA_W-1:0] data_i,
  input  logic                  byte_i,
  input  logic                  signed_i,
  output logic [LSU_DATA_W-1:0] rdata_o
);

  assign rdata_o = extend_load(data_i, byte_i, signed_i);

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller: one request at a time, registered memory
// strobes, extended load result. Define MISALIGN_TRAP_EN to trap misaligned words.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = LSU_ADDR_W,
  parameter int DATA_W  = LSU_DATA_W,
  parameter int MEM_LAT = LSU_MEM_LAT
) (
  input  logic      clk,
  input  logic      rst_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem,
  output logic      busy
);

  localparam int CNT_W = lat_cnt_w(MEM_LAT);

  logic [2:0]        state_q, state_d;
  logic              write_q, byte_q, signed_q;
  logic              rd_stb_q, wr_stb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [ADDR_W-1:0] ea, ea_addr;
  logic [DATA_W-1:0] ext_data;
  logic              accept, trap, last_wait;

  // Only the low ADDR_W bits of the effective address reach memory, so the
  // sum is formed at that width; wrap-around is identical modulo 2^ADDR_W.
  assign ea        = req.req_base[ADDR_W-1:0] + ADDR_W'($signed(req.req_offset));
  assign accept    = req.req_valid && (state_q == ST_IDLE);
  assign last_wait = (state_q == ST_WAIT) && (cnt_q == '0);

`ifdef MISALIGN_TRAP_EN
  assign trap    = !req.req_byte && (ea[1:0] != 2'b00);
  assign ea_addr = ea;
`else
  assign trap    = 1'b0;
  assign ea_addr = req.req_byte ? ea : {ea[ADDR_W-1:2], 2'b00};
`endif

  // NOTE: next-state logic assigns a default first so no path leaves state_d
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = trap ? ST_RESP : ST_SETUP;
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: state_d = ST_WAIT;
      ST_WAIT:   if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP:   if (req.resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: every register, including the datapath holding registers, is reset so
  // the memory bus and response outputs come out of reset at a known 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q  <= state_d;
      rd_stb_q <= (state_q == ST_SETUP) && !write_q;
      wr_stb_q <= (state_q == ST_SETUP) && write_q;

      if (accept && !trap) begin
        write_q  <= req.req_write;
        byte_q   <= req.req_byte;
        signed_q <= req.req_signed;
        addr_q   <= ea_addr;
        wdata_q  <= req.req_wdata;
      end

      if (state_q == ST_STROBE) begin
        cnt_q <= CNT_W'(MEM_LAT - 1);
      end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (accept && trap) begin
        rdata_q <= '0;
      end else if (last_wait) begin
        rdata_q <= write_q ? '0 : ext_data;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= trap;
    end
  end

  assign req.resp_err = err_q;
`else
  assign req.resp_err = 1'b0;
`endif

  lsu_load_extend u_load_extend (
    .data_i   (mem.mem_read_data),
    .byte_i   (byte_q),
    .signed_i (signed_q),
    .rdata_o  (ext_data)
  );

  assign req.req_ready  = (state_q == ST_IDLE);
  assign req.resp_valid = (state_q == ST_RESP);
  assign req.resp_rdata = rdata_q;
  assign busy           = (state_q != ST_IDLE);

  assign mem.mem_address    = addr_q;
  assign mem.mem_write_data = wdata_q;
  assign mem.mem_byte       = byte_q;
  assign mem.mem_read       = rd_stb_q;
  assign mem.mem_write      = wr_stb_q;

endmodule
